// File: rtl/lru_age_tracker_pkg.sv
// rtl/lru_age_tracker_pkg.sv - shared types and helpers for the LRU age tracker
//
// Purpose: age type, age-update opcode, reset-pattern constant and
//          onehot<->binary victim encoding helpers.
// Ports:   none (package).
// Helpers work at the maximum supported width (16 ways, 4-bit index);
// callers size-cast to their own WAYS / WAY_W.

package lru_age_tracker_pkg;

    localparam int LRU_MAX_WAYS  = 16;
    localparam int LRU_MAX_WAY_W = 4;

    typedef logic [LRU_MAX_WAY_W-1:0] lru_age_t;

    typedef enum logic [1:0] {
        LRU_OP_NONE  = 2'd0,
        LRU_OP_TOUCH = 2'd1,
        LRU_OP_INV   = 2'd2
    } lru_op_t;

    // Age of way w in the reset/flush pattern: way index equals age.
    function automatic lru_age_t reset_age(input int w);
        return lru_age_t'(w);
    endfunction

    function automatic logic [LRU_MAX_WAYS-1:0] bin_to_onehot(input lru_age_t b);
        logic [LRU_MAX_WAYS-1:0] oh;
        oh    = '0;
        oh[b] = 1'b1;
        return oh;
    endfunction

    function automatic lru_age_t onehot_to_bin(input logic [LRU_MAX_WAYS-1:0] oh);
        lru_age_t b;
        b = '0;
        for (int i = 0; i < LRU_MAX_WAYS; i++) begin
            if (oh[i]) begin
                b = b | lru_age_t'(i);
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/lru_age_tracker_update.sv
// rtl/lru_age_tracker_update.sv - combinational age-vector update for one set
//
// Purpose: applies one touch or invalidate to a set's age vector.
// Ports:
//   ages_in  in  WAYS x WAY_W  current ages of the set
//   op       in  lru_op_t      none / touch / invalidate
//   way      in  WAY_W         target way
//   ages_out out WAYS x WAY_W  updated ages

module lru_age_update
    import lru_age_tracker_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0][WAY_W-1:0] ages_in,
    input  lru_op_t                    op,
    input  logic [WAY_W-1:0]           way,
    output logic [WAYS-1:0][WAY_W-1:0] ages_out
);

    localparam logic [WAY_W-1:0] AGE_LRU = WAY_W'(WAYS - 1);

    logic [WAY_W-1:0] target_age;

    always_comb begin
        target_age = ages_in[way];
        ages_out   = ages_in;
        for (int i = 0; i < WAYS; i++) begin
            unique case (op)
                LRU_OP_TOUCH: begin
                    if (WAY_W'(i) == way) begin
                        ages_out[i] = '0;
                    end else if (ages_in[i] < target_age) begin
                        ages_out[i] = ages_in[i] + 1'b1;
                    end
                end
                LRU_OP_INV: begin
                    if (WAY_W'(i) == way) begin
                        ages_out[i] = AGE_LRU;
                    end else if (ages_in[i] > target_age) begin
                        ages_out[i] = ages_in[i] - 1'b1;
                    end
                end
                default: ages_out[i] = ages_in[i];
            endcase
        end
    end

endmodule

// File: rtl/lru_age_tracker.sv
// rtl/lru_age_tracker.sv - true-LRU age tracker with registered victim query
//
// Purpose: per-set binary ages (0 = MRU, WAYS-1 = LRU), updated by touch and
//          invalidate, answering victim queries one cycle later using the
//          post-update ages of the queried set.
// Optional feature macro: LRU_WAY_LOCK_EN (adds lock_mask; locked ways are
//          never chosen as victim).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   flush                      reinitialise all sets to the reset pattern
//   touch_valid/set/way        hit or fill update
//   inv_valid/set/way          invalidate update
//   query_valid/set/vmask      victim request with per-way valid bits
//   lock_mask                  (LRU_WAY_LOCK_EN only) per-way victim lock
//   victim_valid/way/onehot    registered victim response

module lru_age_tracker
    import lru_age_tracker_pkg::*;
#(
    parameter int WAYS     = 4,
    parameter int NUM_SETS = 64,
    localparam int WAY_W   = $clog2(WAYS),
    localparam int SET_W   = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             touch_valid,
    input  logic [SET_W-1:0] touch_set,
    input  logic [WAY_W-1:0] touch_way,
    input  logic             inv_valid,
    input  logic [SET_W-1:0] inv_set,
    input  logic [WAY_W-1:0] inv_way,
    input  logic             query_valid,
    input  logic [SET_W-1:0] query_set,
    input  logic [WAYS-1:0]  query_vmask,
`ifdef LRU_WAY_LOCK_EN
    input  logic [WAYS-1:0]  lock_mask,
`endif
    output logic             victim_valid,
    output logic [WAY_W-1:0] victim_way,
    output logic [WAYS-1:0]  victim_onehot
);

    typedef logic [WAYS-1:0][WAY_W-1:0] age_vec_t;

    age_vec_t age_q [NUM_SETS];

    age_vec_t reset_vec;
    age_vec_t touch_ages;
    age_vec_t inv_base;
    age_vec_t inv_ages;
    age_vec_t query_ages;
    lru_op_t  touch_op;
    lru_op_t  inv_op;
    logic     same_set;

    logic [WAYS-1:0]  lock;
    logic [WAYS-1:0]  inv_cand;
    logic [WAYS-1:0]  first_inv;
    logic [WAYS-1:0]  sel_onehot;
    logic [WAY_W-1:0] sel_way;
    logic [WAY_W-1:0] best_age;
    logic [WAY_W-1:0] best_way;
    logic             best_found;

`ifdef LRU_WAY_LOCK_EN
    assign lock = lock_mask;
`else
    assign lock = '0;
`endif

    always_comb begin
        reset_vec = '0;
        for (int w = 0; w < WAYS; w++) begin
            reset_vec[w] = WAY_W'(reset_age(w));
        end
    end

    assign touch_op = touch_valid ? LRU_OP_TOUCH : LRU_OP_NONE;
    assign inv_op   = inv_valid   ? LRU_OP_INV   : LRU_OP_NONE;
    assign same_set = touch_valid && (touch_set == inv_set);

    lru_age_update #(.WAYS(WAYS), .WAY_W(WAY_W)) u_touch (
        .ages_in  (age_q[touch_set]),
        .op       (touch_op),
        .way      (touch_way),
        .ages_out (touch_ages)
    );

    // Same-set invalidate acts on the touched result, so touch then invalidate
    // of one way leaves that way LRU.
    assign inv_base = same_set ? touch_ages : age_q[inv_set];

    lru_age_update #(.WAYS(WAYS), .WAY_W(WAY_W)) u_inv (
        .ages_in  (inv_base),
        .op       (inv_op),
        .way      (inv_way),
        .ages_out (inv_ages)
    );

    // inv_ages already contains the touch when both hit the same set, so the
    // invalidate result takes precedence for that set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(reset_age(w));
                end
            end
        end else if (flush) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(reset_age(w));
                end
            end
        end else begin
            for (int s = 0; s < NUM_SETS; s++) begin
                if (inv_valid && inv_set == SET_W'(s)) begin
                    age_q[s] <= inv_ages;
                end else if (touch_valid && touch_set == SET_W'(s)) begin
                    age_q[s] <= touch_ages;
                end
            end
        end
    end

    // Bypass: the victim is chosen from this cycle's post-update ages.
    always_comb begin
        if (flush) begin
            query_ages = reset_vec;
        end else if (inv_valid && inv_set == query_set) begin
            query_ages = inv_ages;
        end else if (touch_valid && touch_set == query_set) begin
            query_ages = touch_ages;
        end else begin
            query_ages = age_q[query_set];
        end
    end

    // Lowest-index invalid, unlocked way: isolate the lowest set bit.
    assign inv_cand  = ~query_vmask & ~lock;
    assign first_inv = inv_cand & (~inv_cand + 1'b1);

    always_comb begin
        best_found = 1'b0;
        best_age   = '0;
        best_way   = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (!lock[i] && (!best_found || query_ages[i] > best_age)) begin
                best_found = 1'b1;
                best_age   = query_ages[i];
                best_way   = WAY_W'(i);
            end
        end
    end

    always_comb begin
        sel_way    = '0;
        sel_onehot = '0;
        if (|inv_cand) begin
            sel_onehot = first_inv;
            sel_way    = WAY_W'(onehot_to_bin(LRU_MAX_WAYS'(first_inv)));
        end else if (best_found) begin
            sel_way    = best_way;
            sel_onehot = WAYS'(bin_to_onehot(lru_age_t'(best_way)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            victim_valid  <= 1'b0;
            victim_way    <= '0;
            victim_onehot <= '0;
        end else begin
            victim_valid <= query_valid;
            if (query_valid) begin
                victim_way    <= sel_way;
                victim_onehot <= sel_onehot;
            end
        end
    end

endmodule
